// File: rtl/hwag_pkg.sv
// Shared types and constants for the HWAG tooth-capture path and its crank-wheel emulator.
package hwag_pkg;

  localparam int unsigned CWE_TEETH_TOTAL   = 32'd60;
  localparam int unsigned CWE_TEETH_MISSING = 32'd2;
  localparam int unsigned CWE_MIN_PERIOD    = 32'd4;
  localparam int unsigned CWE_PER_WIDTH     = 32'd24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    GAP  = 2'd3
  } cwe_state_t;

endpackage

// File: rtl/cwe_phase_timer.sv
// Loadable down-counter with terminal-count flag; times the HIGH, LOW and GAP phases.
module cwe_phase_timer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // A load always wins; otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {WIDTH{1'b0}}) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/crank_wheel_emulator.sv
// Crank-wheel emulator: emits a TEETH_TOTAL-minus-TEETH_MISSING tooth pattern at a
// programmable period and reports tooth index, gap and once-per-revolution markers.
module crank_wheel_emulator
  import hwag_pkg::*;
#(
  parameter int unsigned PER_WIDTH     = CWE_PER_WIDTH,
  parameter int unsigned TEETH_TOTAL   = CWE_TEETH_TOTAL,
  parameter int unsigned TEETH_MISSING = CWE_TEETH_MISSING,
  parameter int unsigned MIN_PERIOD    = CWE_MIN_PERIOD,
  parameter logic        IDLE_LEVEL    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [PER_WIDTH-1:0] period,
  input  logic                 period_wr,
  output logic                 tooth_out,
  output logic [7:0]           tooth_num,
  output logic                 gap,
  output logic                 rev_pulse,
  output logic                 running
);

  localparam int unsigned          TW      = PER_WIDTH + 32'd8;
  localparam logic [TW-1:0]        ONE_TW  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0]        MISS_TW = TW'(TEETH_MISSING);
  localparam logic [7:0]           LAST    = 8'(TEETH_TOTAL - TEETH_MISSING - 32'd1);
  localparam logic [PER_WIDTH-1:0] MIN_P   = PER_WIDTH'(MIN_PERIOD);

  cwe_state_t           state_q, state_d;
  logic [PER_WIDTH-1:0] shadow_q, shadow_d;
  logic [PER_WIDTH-1:0] active_q, active_d;
  logic [7:0]           tooth_num_q, tooth_num_d;
  logic                 tooth_out_q, tooth_out_d;
  logic                 gap_q, gap_d;
  logic                 rev_pulse_q, rev_pulse_d;
  logic                 running_q, running_d;

  logic                 tmr_load_s;
  logic [TW-1:0]        tmr_val_s;
  logic                 tmr_tc_s;
  logic [PER_WIDTH-1:0] sh_eff_s;
  logic                 stop_s;
  logic [TW-1:0]        hi_sh_load_s;
  logic [TW-1:0]        hi_eff_load_s;
  logic [TW-1:0]        lo_load_s;
  logic [TW-1:0]        gap_load_s;

  // A write landing on the boundary edge is the value copied at that boundary
  assign sh_eff_s      = period_wr ? period : shadow_q;
  assign stop_s        = (!ena) || (sh_eff_s < MIN_P);
  assign hi_sh_load_s  = {8'd0, (shadow_q >> 1'b1)} - ONE_TW;
  assign hi_eff_load_s = {8'd0, (sh_eff_s >> 1'b1)} - ONE_TW;
  assign lo_load_s     = {8'd0, (active_q - (active_q >> 1'b1))} - ONE_TW;
  assign gap_load_s    = (MISS_TW * {8'd0, active_q}) - ONE_TW;

  cwe_phase_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Next-state, period copy, tooth index and phase-timer reload
  always_comb begin
    state_d     = state_q;
    shadow_d    = sh_eff_s;
    active_d    = active_q;
    tooth_num_d = tooth_num_q;
    rev_pulse_d = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = {TW{1'b0}};
    case (state_q)
      IDLE: begin
        if (ena && (shadow_q >= MIN_P)) begin
          state_d     = HIGH;
          active_d    = shadow_q;
          tooth_num_d = 8'd0;
          rev_pulse_d = 1'b1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = hi_sh_load_s;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (tmr_tc_s) begin
          state_d    = LOW;
          tmr_load_s = 1'b1;
          tmr_val_s  = lo_load_s;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (!tmr_tc_s) begin
          state_d = LOW;
        end else if (stop_s) begin
          state_d = IDLE;
        end else if (tooth_num_q == LAST) begin
          state_d    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = gap_load_s;
        end else begin
          state_d     = HIGH;
          active_d    = sh_eff_s;
          tooth_num_d = tooth_num_q + 8'd1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = hi_eff_load_s;
        end
      end
      GAP: begin
        if (!tmr_tc_s) begin
          state_d = GAP;
        end else if (stop_s) begin
          state_d = IDLE;
        end else begin
          state_d     = HIGH;
          active_d    = sh_eff_s;
          tooth_num_d = 8'd0;
          rev_pulse_d = 1'b1;
          tmr_load_s  = 1'b1;
          tmr_val_s   = hi_eff_load_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    tooth_out_d = (state_d == HIGH) ? ~IDLE_LEVEL : IDLE_LEVEL;
    gap_d       = (state_d == GAP);
    running_d   = (state_d != IDLE);
  end

  // FSM state, period registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shadow_q    <= {PER_WIDTH{1'b0}};
      active_q    <= {PER_WIDTH{1'b0}};
      tooth_num_q <= 8'd0;
      tooth_out_q <= IDLE_LEVEL;
      gap_q       <= 1'b0;
      rev_pulse_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      tooth_num_q <= tooth_num_d;
      tooth_out_q <= tooth_out_d;
      gap_q       <= gap_d;
      rev_pulse_q <= rev_pulse_d;
      running_q   <= running_d;
    end
  end

  assign tooth_out = tooth_out_q;
  assign tooth_num = tooth_num_q;
  assign gap       = gap_q;
  assign rev_pulse = rev_pulse_q;
  assign running   = running_q;

endmodule
